mole_scheduler: RTL and testbench
=================================

MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 SHALL have parameter LIFE_BASE, default 4: minimum mole up-time in ticks.
REQ-002 SHALL have parameter GAP_BASE, default 2: minimum empty time between moles in ticks.
REQ-003 SHALL have parameter ROUND_TICKS, default 1200: round length in ticks, 16-bit.
REQ-004 SHALL have port clk, input, 1: system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port gamestart, input, 1: one-clk start pulse, the same signal that reseeds the random generator.
REQ-007 SHALL have port tick, input, 1: one-clk game-time strobe.
REQ-008 SHALL have port randout, input, 32: random word from the generator.
REQ-009 SHALL have port hit, input, 16: per-hole key strobes, any number set.
REQ-010 SHALL have port refreshSig, output, 1: one-clk pulse that advances the generator.
REQ-011 SHALL have port mole, output, 16: one-hot raised-mole mask, or zero.
REQ-012 SHALL have port score, output, 8: hit count, saturating.
REQ-013 SHALL have port miss, output, 8: expired-mole count, saturating.
REQ-014 SHALL have port done, output, 1: high while the round is over.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, SPAWN, UP, DONE.
REQ-016 gamestart=1 in any state SHALL, next edge: score=0, miss=0, round_cnt=ROUND_TICKS, gap_cnt=GAP_BASE, mole=0, done=0, state=WAIT; this overrides every other event in that cycle.
REQ-017 IDLE: mole=0, done=0; leave only via gamestart.
REQ-018 WAIT: each tick decrements gap_cnt; when tick arrives with gap_cnt<=1, state SHALL become SPAWN.
REQ-019 SPAWN, 1 cycle: latch hole=randout[3:0], life_cnt=LIFE_BASE+randout[7:4] (5-bit, max 19), mole=1<<hole; state=UP.
REQ-020 refreshSig SHALL be high exactly during the first UP cycle after SPAWN and low at all other times.
REQ-021 UP: each tick decrements life_cnt; hit[hole]=1 SHALL, next edge, clear mole, score+1 (hold at 255), gap_cnt=GAP_BASE+randout[10:8], state=WAIT.
REQ-022 UP: tick with life_cnt<=1 and no hit[hole] SHALL, next edge, clear mole, miss+1 (hold at 255), load gap_cnt as in REQ-021, state=WAIT.
REQ-023 Hit and expiring tick in the same cycle SHALL count as a hit only.
REQ-024 hit bits other than hit[hole], and any hit outside UP, SHALL be ignored.
REQ-025 round_cnt SHALL decrement on each tick in WAIT, SPAWN and UP.
REQ-026 When a tick makes round_cnt reach 0, next edge: state=DONE, mole=0, done=1.
REQ-027 A qualifying hit in that same cycle SHALL still increment score; an expiry in that same cycle SHALL NOT increment miss.
REQ-028 DONE: score/miss hold, mole=0, done=1, tick ignored; leave only via gamestart.
REQ-029 Hit-to-update latency SHALL be 1 clk: score and mole change at the edge ending the hit cycle.

Reset
REQ-030 rst=0 SHALL immediately force: state=IDLE, mole=0, score=0, miss=0, done=0, refreshSig=0, all counters 0.
REQ-031 Reset mid-round SHALL discard the round; after release the block stays IDLE until gamestart.

Verification
REQ-032 Reset, then gamestart, then 2 ticks -> SPAWN; randout=0x0000_0235 -> mole=0x0020, refreshSig pulses 1 clk, life_cnt=7.
REQ-033 Mole at hole 5, hit=0x0020 -> score 0->1, mole=0 next clk; hit=0x0010 instead -> no change.
REQ-034 Mole up, no hit, 7 ticks -> miss=1, mole=0; hit[5] with the 7th tick -> score=1, miss=0.
REQ-035 ROUND_TICKS=10, ticks continuous -> done=1, mole=0 after the 10th tick; later hits and ticks leave score and miss unchanged.
REQ-036 score=255 plus another hit -> score stays 255; gamestart -> score=0, miss=0, WAIT.
REQ-037 rst low while mole up -> mole=0, score=0 asynchronously; ticks after release -> stays IDLE.

Source files
------------

// File: rtl/mole_scheduler.sv
// Whack-a-mole round scheduler: raises one random mole at a time and counts hits and expiries.
// Latency: hit/expiry results land on the edge ending that cycle; no backpressure, paced by tick.
module mole_scheduler #(
  parameter int unsigned LIFE_BASE   = 4,
  parameter int unsigned GAP_BASE    = 2,
  parameter int unsigned ROUND_TICKS = 1200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gamestart,
  input  logic        tick,
  input  logic [31:0] randout,
  input  logic [15:0] hit,
  output logic        refreshSig,
  output logic [15:0] mole,
  output logic [7:0]  score,
  output logic [7:0]  miss,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    SPAWN = 3'd2,
    UP    = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [15:0] ROUND_INIT = 16'(ROUND_TICKS);
  localparam logic [7:0]  GAP_INIT   = 8'(GAP_BASE);
  localparam logic [4:0]  LIFE_INIT  = 5'(LIFE_BASE);

  state_t      state_q, state_d;
  logic [3:0]  hole_q, hole_d;
  logic [15:0] mole_q, mole_d;
  logic [4:0]  life_q, life_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] round_q, round_d;
  logic [7:0]  score_q, score_d;
  logic [7:0]  miss_q, miss_d;
  logic        refresh_q, refresh_d;

  logic        in_round;
  logic        round_end;
  logic        hole_hit;
  logic [7:0]  gap_reload;
  logic        unused_rand;

  assign unused_rand = ^randout[31:11];

  assign in_round   = (state_q == WAIT) || (state_q == SPAWN) || (state_q == UP);
  assign round_end  = in_round && tick && (round_q <= 16'd1);
  assign hole_hit   = (state_q == UP) && hit[hole_q];
  assign gap_reload = GAP_INIT + {5'd0, randout[10:8]};

  always_comb begin
    state_d   = state_q;
    hole_d    = hole_q;
    mole_d    = mole_q;
    life_d    = life_q;
    gap_d     = gap_q;
    round_d   = round_q;
    score_d   = score_q;
    miss_d    = miss_q;
    refresh_d = 1'b0;

    if (in_round && tick && (round_q != 16'd0)) begin
      round_d = round_q - 16'd1;
    end

    case (state_q)
      WAIT: begin
        if (tick) begin
          if (gap_q != 8'd0) gap_d = gap_q - 8'd1;
          if (gap_q <= 8'd1) state_d = SPAWN;
        end
      end
      SPAWN: begin
        hole_d    = randout[3:0];
        life_d    = LIFE_INIT + {1'b0, randout[7:4]};
        mole_d    = 16'd1 << randout[3:0];
        refresh_d = 1'b1;
        state_d   = UP;
      end
      UP: begin
        // A hit wins over an expiring tick in the same cycle.
        if (hole_hit) begin
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          mole_d  = '0;
          gap_d   = gap_reload;
          state_d = WAIT;
        end else if (tick) begin
          if (life_q != 5'd0) life_d = life_q - 5'd1;
          if (life_q <= 5'd1) begin
            if (!round_end) miss_d = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;
            mole_d  = '0;
            gap_d   = gap_reload;
            state_d = WAIT;
          end
        end
      end
      default: begin
      end
    endcase

    // The round ending keeps any score already taken this cycle but drops the mole.
    if (round_end) begin
      state_d   = DONE;
      mole_d    = '0;
      refresh_d = 1'b0;
    end

    if (gamestart) begin
      state_d   = WAIT;
      mole_d    = '0;
      gap_d     = GAP_INIT;
      round_d   = ROUND_INIT;
      score_d   = '0;
      miss_d    = '0;
      refresh_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      hole_q    <= '0;
      mole_q    <= '0;
      life_q    <= '0;
      gap_q     <= '0;
      round_q   <= '0;
      score_q   <= '0;
      miss_q    <= '0;
      refresh_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hole_q    <= hole_d;
      mole_q    <= mole_d;
      life_q    <= life_d;
      gap_q     <= gap_d;
      round_q   <= round_d;
      score_q   <= score_d;
      miss_q    <= miss_d;
      refresh_q <= refresh_d;
    end
  end

  assign refreshSig = refresh_q;
  assign mole       = mole_q;
  assign score      = score_q;
  assign miss       = miss_q;
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler: directed table, corner sequences, random vs. reference model.
module tb_mole_scheduler;

  localparam int GAP  = 2;
  localparam int LIFE = 4;

  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_SPAWN = 2;
  localparam int P_UP    = 3;
  localparam int P_DONE  = 4;

  logic        clk;
  logic        rst;
  logic        gamestart;
  logic        tick;
  logic [31:0] randout;
  logic [15:0] hit;

  logic        refresh0, refresh1;
  logic [15:0] mole0, mole1;
  logic [7:0]  score0, score1, miss0, miss1;
  logic        done0, done1;

  int checks = 0;
  int errors = 0;

  mole_scheduler dut (
    .clk(clk), .rst(rst), .gamestart(gamestart), .tick(tick), .randout(randout), .hit(hit),
    .refreshSig(refresh0), .mole(mole0), .score(score0), .miss(miss0), .done(done0)
  );

  mole_scheduler #(.ROUND_TICKS(10)) dut_r (
    .clk(clk), .rst(rst), .gamestart(gamestart), .tick(tick), .randout(randout), .hit(hit),
    .refreshSig(refresh1), .mole(mole1), .score(score1), .miss(miss1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit gs, input bit tk, input logic [31:0] r, input logic [15:0] h);
    @(negedge clk);
    gamestart = gs;
    tick      = tk;
    randout   = r;
    hit       = h;
    @(posedge clk);
    #1;
  endtask

  // Reference model: game rules expressed with plain integers.
  typedef struct {
    int phase;
    int hole;
    int life;
    int gap;
    int rounds;
    int score;
    int miss;
    bit refresh;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.phase = P_IDLE; m.hole = 0; m.life = 0; m.gap = 0;
    m.rounds = 0; m.score = 0; m.miss = 0; m.refresh = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit gs, bit tk, logic [31:0] r, logic [15:0] h, int rt);
    mdl_t n;
    bit playing, ends;
    n = m;
    n.refresh = 1'b0;
    if (gs) begin
      n.phase = P_WAIT; n.gap = GAP; n.rounds = rt; n.score = 0; n.miss = 0;
      return n;
    end
    playing = (m.phase == P_WAIT) || (m.phase == P_SPAWN) || (m.phase == P_UP);
    ends = playing && tk && (m.rounds <= 1);
    if (playing && tk && m.rounds > 0) n.rounds = m.rounds - 1;
    if (m.phase == P_WAIT && tk) begin
      n.gap = (m.gap > 0) ? m.gap - 1 : 0;
      if (m.gap <= 1) n.phase = P_SPAWN;
    end else if (m.phase == P_SPAWN) begin
      n.hole = int'(r[3:0]);
      n.life = LIFE + int'(r[7:4]);
      n.phase = P_UP;
      n.refresh = 1'b1;
    end else if (m.phase == P_UP) begin
      if (h[m.hole] == 1'b1) begin
        n.score = (m.score < 255) ? m.score + 1 : 255;
        n.gap = GAP + int'(r[10:8]);
        n.phase = P_WAIT;
      end else if (tk) begin
        n.life = (m.life > 0) ? m.life - 1 : 0;
        if (m.life <= 1) begin
          if (!ends) n.miss = (m.miss < 255) ? m.miss + 1 : 255;
          n.gap = GAP + int'(r[10:8]);
          n.phase = P_WAIT;
        end
      end
    end
    if (ends) begin
      n.phase = P_DONE;
      n.refresh = 1'b0;
    end
    return n;
  endfunction

  task automatic cmp_model(input string tag, input mdl_t m, input logic [15:0] mo,
                           input logic [7:0] sc, input logic [7:0] mi, input logic dn, input logic rf);
    logic [15:0] exp_mole;
    exp_mole = (m.phase == P_UP) ? (16'd1 << m.hole) : 16'd0;
    chk({tag, ".mole"}, mo, exp_mole);
    chk({tag, ".score"}, sc, m.score);
    chk({tag, ".miss"}, mi, m.miss);
    chk({tag, ".done"}, dn, (m.phase == P_DONE));
    chk({tag, ".refresh"}, rf, m.refresh);
  endtask

  typedef struct {
    bit          gs;
    bit          tk;
    logic [31:0] r;
    logic [15:0] h;
    logic [15:0] mole;
    logic [7:0]  score;
    logic [7:0]  miss;
    bit          done;
    bit          refr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    mdl_t m0, m1;
    bit gs, tk;
    logic [31:0] r;
    logic [15:0] h;

    // gs, tick, randout, hit  ->  mole, score, miss, done, refreshSig
    vecs.push_back('{1'b1, 1'b0, 32'h0,   16'h0,    16'h0,    8'd0, 8'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0,   16'h0,    16'h0,    8'd0, 8'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0,   16'hFFFF, 16'h0,    8'd0, 8'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h235, 16'h0,    16'h0020, 8'd0, 8'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h235, 16'h0010, 16'h0020, 8'd0, 8'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h300, 16'h0020, 16'h0,    8'd1, 8'd0, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b0, 1'b1, 32'h0, 16'h0, 16'h0, 8'd1, 8'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h235, 16'h0,    16'h0020, 8'd1, 8'd0, 1'b0, 1'b1});
    for (int i = 0; i < 6; i++)
      vecs.push_back('{1'b0, 1'b1, 32'h0, 16'h0, 16'h0020, 8'd1, 8'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h0,   16'h0,    16'h0,    8'd1, 8'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,   16'h0020, 16'h0,    8'd1, 8'd1, 1'b0, 1'b0});

    rst = 1'b0; gamestart = 1'b0; tick = 1'b0; randout = '0; hit = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset.mole", mole0, 16'h0);
    chk("reset.score", score0, 8'd0);
    chk("reset.miss", miss0, 8'd0);
    chk("reset.done", done0, 1'b0);
    chk("reset.refresh", refresh0, 1'b0);
    rst = 1'b1;
    drive(1'b0, 1'b1, 32'h0, 16'hFFFF);
    chk("idle.mole", mole0, 16'h0);
    chk("idle.done", done0, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].gs, vecs[i].tk, vecs[i].r, vecs[i].h);
      chk($sformatf("vec%0d.mole", i), mole0, vecs[i].mole);
      chk($sformatf("vec%0d.score", i), score0, vecs[i].score);
      chk($sformatf("vec%0d.miss", i), miss0, vecs[i].miss);
      chk($sformatf("vec%0d.done", i), done0, vecs[i].done);
      chk($sformatf("vec%0d.refresh", i), refresh0, vecs[i].refr);
    end

    // Hit arriving together with the expiring tick counts as a hit only.
    drive(1'b1, 1'b0, 32'h0, 16'h0);
    drive(1'b0, 1'b1, 32'h0, 16'h0);
    drive(1'b0, 1'b1, 32'h0, 16'h0);
    drive(1'b0, 1'b0, 32'h235, 16'h0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 32'h0, 16'h0);
    chk("hitexp.pre_mole", mole0, 16'h0020);
    drive(1'b0, 1'b1, 32'h0, 16'h0020);
    chk("hitexp.score", score0, 8'd1);
    chk("hitexp.miss", miss0, 8'd0);
    chk("hitexp.mole", mole0, 16'h0);

    // Ten-tick round: a hit on the last tick still scores.
    drive(1'b1, 1'b0, 32'h0F5, 16'h0);
    for (int i = 1; i <= 9; i++) drive(1'b0, 1'b1, 32'h0F5, 16'h0);
    chk("rnd1.pre_done", done1, 1'b0);
    chk("rnd1.pre_mole", mole1, 16'h0020);
    drive(1'b0, 1'b1, 32'h0F5, 16'h0020);
    chk("rnd1.done", done1, 1'b1);
    chk("rnd1.mole", mole1, 16'h0);
    chk("rnd1.score", score1, 8'd1);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'h0F5, 16'hFFFF);
    chk("rnd1.hold_score", score1, 8'd1);
    chk("rnd1.hold_miss", miss1, 8'd0);
    chk("rnd1.hold_done", done1, 1'b1);
    chk("rnd1.hold_mole", mole1, 16'h0);

    // Ten-tick round: an expiry on the last tick is not a miss.
    drive(1'b1, 1'b0, 32'h035, 16'h0);
    for (int i = 1; i <= 9; i++) drive(1'b0, 1'b1, 32'h035, 16'h0);
    chk("rnd2.pre_mole", mole1, 16'h0020);
    drive(1'b0, 1'b1, 32'h035, 16'h0);
    chk("rnd2.done", done1, 1'b1);
    chk("rnd2.miss", miss1, 8'd0);
    chk("rnd2.mole", mole1, 16'h0);

    // Score saturation, then restart.
    drive(1'b1, 1'b0, 32'h5, 16'h0);
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b1, 32'h5, 16'h0);
      drive(1'b0, 1'b1, 32'h5, 16'h0);
      drive(1'b0, 1'b0, 32'h5, 16'h0);
      drive(1'b0, 1'b0, 32'h5, 16'h0020);
      if (i >= 253) chk($sformatf("sat%0d.score", i), score0, (i + 1 > 255) ? 255 : i + 1);
    end
    drive(1'b1, 1'b0, 32'h0, 16'h0);
    chk("restart.score", score0, 8'd0);
    chk("restart.miss", miss0, 8'd0);
    chk("restart.done", done0, 1'b0);
    drive(1'b0, 1'b1, 32'h0, 16'h0);
    drive(1'b0, 1'b1, 32'h0, 16'h0);
    drive(1'b0, 1'b0, 32'h235, 16'h0);
    chk("restart.mole", mole0, 16'h0020);

    // Asynchronous reset with a mole up and a non-zero score.
    drive(1'b0, 1'b0, 32'h200, 16'h0020);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'h0, 16'h0);
    drive(1'b0, 1'b0, 32'h0F5, 16'h0);
    chk("arst.pre_mole", mole0, 16'h0020);
    chk("arst.pre_score", score0, 8'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.mole", mole0, 16'h0);
    chk("arst.score", score0, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, $urandom, 16'hFFFF);
    chk("arst.idle_mole", mole0, 16'h0);
    chk("arst.idle_score", score0, 8'd0);
    chk("arst.idle_done", done0, 1'b0);
    chk("arst.idle_refresh", refresh0, 1'b0);

    // Randomized run against the reference model, both round lengths.
    m0 = mdl_reset();
    m1 = mdl_reset();
    for (int n = 0; n < 4000; n++) begin
      gs = (n == 0) || ($urandom_range(0, 1499) == 0);
      tk = ($urandom_range(0, 2) != 0);
      r  = $urandom;
      h  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      if (m0.phase == P_UP && $urandom_range(0, 4) == 0) h[m0.hole] = 1'b1;
      drive(gs, tk, r, h);
      m0 = mdl_step(m0, gs, tk, r, h, 1200);
      m1 = mdl_step(m1, gs, tk, r, h, 10);
      cmp_model($sformatf("rnd%0d.dut", n), m0, mole0, score0, miss0, done0, refresh0);
      cmp_model($sformatf("rnd%0d.dut_r", n), m1, mole1, score1, miss1, done1, refresh1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
